fluid_dispense_ctrl: RTL and testbench

//  Multi-channel sequential fluid dispenser. Accepts one purchase request at a time over a valid/ready handshake.

---
 rtl/fluid_dispense_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_fluid_dispense_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fluid_dispense_ctrl.sv
// Sequential multi-channel fluid dispenser: visit tracking, per-channel stock, loyalty pricing.
// Optional macro DISPENSE_ABORT_EN: abort during DISPENSE closes the valve and bills dispensed litres only.
module fluid_dispense_ctrl #(
    parameter int NUM_FLUIDS = 4,
    parameter int NUM_USERS  = 16,
    parameter int VOL_W      = 8,
    parameter int PRICE_W    = 16,
    parameter int STOCK_W    = 16,
    parameter int STOCK_INIT = 100,
    parameter int LOW_THRESH = 10,
    parameter logic [NUM_FLUIDS*PRICE_W-1:0] PRICE_TABLE = {16'd80, 16'd50, 16'd30, 16'd10},
    localparam int UW = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [UW-1:0]         req_user,
    input  logic [2:0]            req_fluid,
    input  logic [VOL_W-1:0]      req_vol,
    input  logic                  restock_valid,
    input  logic [2:0]            restock_fluid,
    input  logic [STOCK_W-1:0]    restock_amt,
    input  logic                  abort,
    output logic [NUM_FLUIDS-1:0] valve_open,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [1:0]            resp_status,
    output logic [7:0]            resp_visits,
    output logic [7:0]            resp_disc,
    output logic [PRICE_W-1:0]    resp_orig,
    output logic [PRICE_W-1:0]    resp_final,
    output logic [STOCK_W-1:0]    resp_remaining,
    output logic [NUM_FLUIDS-1:0] low_stock
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_PRICE, S_DISP, S_DONE} state_t;

    localparam logic [PRICE_W+7:0] L_HUNDRED = (PRICE_W+8)'(100);

    state_t                r_state;
    logic [UW-1:0]         r_user;
    logic [2:0]            r_fluid;
    logic [VOL_W-1:0]      r_vol, r_cnt;
    logic [NUM_FLUIDS-1:0] r_valve;
    logic                  r_resp_valid;
    logic [1:0]            r_status;
    logic [7:0]            r_resp_visits, r_disc;
    logic [PRICE_W-1:0]    r_orig, r_final;
    logic [STOCK_W-1:0]    r_rem;
    logic [7:0]            r_visits [NUM_USERS];
    logic [STOCK_W-1:0]    r_stock  [NUM_FLUIDS];

    logic                  w_abort, w_disp, w_fluid_ok, w_reject;
    logic [STOCK_W-1:0]    w_stock_nxt [NUM_FLUIDS];
    logic [STOCK_W-1:0]    w_sel_stock, w_sel_nxt;
    logic [PRICE_W-1:0]    w_sel_price, w_orig_full;
    logic [7:0]            w_visit_inc, w_disc;

    function automatic logic [PRICE_W-1:0] f_price(input logic [VOL_W-1:0] vol,
                                                   input logic [PRICE_W-1:0] rate);
        logic [VOL_W+PRICE_W-1:0] prod;
        prod = {{PRICE_W{1'b0}}, vol} * {{VOL_W{1'b0}}, rate};
        return (|prod[VOL_W+PRICE_W-1:PRICE_W]) ? '1 : prod[PRICE_W-1:0];
    endfunction

    function automatic logic [PRICE_W-1:0] f_final(input logic [PRICE_W-1:0] orig,
                                                   input logic [7:0] disc);
        logic [PRICE_W+7:0] cut;
        cut = ({8'd0, orig} * {{PRICE_W{1'b0}}, disc}) / L_HUNDRED;
        return orig - cut[PRICE_W-1:0];
    endfunction

`ifdef DISPENSE_ABORT_EN
    assign w_abort = abort && (r_state == S_DISP);
`else
    logic w_unused_abort;
    assign w_unused_abort = abort;
    assign w_abort        = 1'b0;
`endif

    assign w_disp      = (r_state == S_DISP) && !w_abort;
    assign w_fluid_ok  = int'(r_fluid) < NUM_FLUIDS;
    assign w_reject    = !w_fluid_ok || (r_vol == '0) || (STOCK_W'(r_vol) > w_sel_stock);
    assign w_visit_inc = (r_visits[r_user] == 8'hFF) ? 8'hFF : r_visits[r_user] + 8'd1;
    assign w_disc      = (w_visit_inc < 8'd3) ? 8'd0 : (w_visit_inc == 8'd3) ? 8'd10 : 8'd20;
    assign w_orig_full = f_price(r_vol, w_sel_price);

    // Restock adds and dispense removes in the same cycle; result saturates at full scale.
    always_comb begin
        for (int i = 0; i < NUM_FLUIDS; i++) begin
            logic [STOCK_W:0] w_sum;
            w_sum = {1'b0, r_stock[i]};
            if (restock_valid && restock_fluid == 3'(i))
                w_sum = w_sum + {1'b0, restock_amt};
            if (w_disp && r_fluid == 3'(i))
                w_sum = w_sum - (STOCK_W+1)'(1);
            w_stock_nxt[i] = w_sum[STOCK_W] ? '1 : w_sum[STOCK_W-1:0];
        end
    end

    always_comb begin
        w_sel_stock = '0;
        w_sel_nxt   = '0;
        w_sel_price = '0;
        for (int i = 0; i < NUM_FLUIDS; i++) begin
            if (r_fluid == 3'(i)) begin
                w_sel_stock = r_stock[i];
                w_sel_nxt   = w_stock_nxt[i];
                w_sel_price = PRICE_TABLE[i*PRICE_W +: PRICE_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FLUIDS; i++)
            low_stock[i] = r_stock[i] < STOCK_W'(LOW_THRESH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_user        <= '0;
            r_fluid       <= '0;
            r_vol         <= '0;
            r_cnt         <= '0;
            r_valve       <= '0;
            r_resp_valid  <= 1'b0;
            r_status      <= '0;
            r_resp_visits <= '0;
            r_disc        <= '0;
            r_orig        <= '0;
            r_final       <= '0;
            r_rem         <= '0;
            for (int i = 0; i < NUM_USERS; i++)  r_visits[i] <= '0;
            for (int i = 0; i < NUM_FLUIDS; i++) r_stock[i]  <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < NUM_FLUIDS; i++) r_stock[i] <= w_stock_nxt[i];
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_user  <= req_user;
                    r_fluid <= req_fluid;
                    r_vol   <= req_vol;
                    r_state <= S_LOOKUP;
                end
                S_LOOKUP: if (w_reject) begin
                    r_status      <= (!w_fluid_ok || r_vol == '0) ? 2'd2 : 2'd1;
                    r_resp_visits <= r_visits[r_user];
                    r_disc        <= '0;
                    r_orig        <= '0;
                    r_final       <= '0;
                    r_rem         <= w_sel_stock;
                    r_resp_valid  <= 1'b1;
                    r_state       <= S_DONE;
                end else begin
                    r_state <= S_PRICE;
                end
                S_PRICE: begin
                    r_visits[r_user] <= w_visit_inc;
                    r_resp_visits    <= w_visit_inc;
                    r_disc           <= w_disc;
                    r_orig           <= w_orig_full;
                    r_final          <= f_final(w_orig_full, w_disc);
                    r_cnt            <= r_vol;
                    r_valve          <= NUM_FLUIDS'(1) << r_fluid;
                    r_state          <= S_DISP;
                end
                S_DISP:
`ifdef DISPENSE_ABORT_EN
                if (w_abort) begin
                    // r_cnt still holds the litres not yet poured
                    r_orig       <= f_price(r_vol - r_cnt, w_sel_price);
                    r_final      <= f_final(f_price(r_vol - r_cnt, w_sel_price), r_disc);
                    r_status     <= 2'd3;
                    r_rem        <= w_sel_nxt;
                    r_valve      <= '0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end else
`endif
                begin
                    r_cnt <= r_cnt - VOL_W'(1);
                    if (r_cnt == VOL_W'(1)) begin
                        r_status     <= 2'd0;
                        r_rem        <= w_sel_nxt;
                        r_valve      <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: if (resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign valve_open     = r_valve & ~{NUM_FLUIDS{w_abort}};
    assign resp_valid     = r_resp_valid;
    assign resp_status    = r_status;
    assign resp_visits    = r_resp_visits;
    assign resp_disc      = r_disc;
    assign resp_orig      = r_orig;
    assign resp_final     = r_final;
    assign resp_remaining = r_rem;
endmodule

// File: tb/tb_fluid_dispense_ctrl.sv
// Bench for fluid_dispense_ctrl: directed + randomized purchases checked against a litre/visit ledger.
`timescale 1ns/1ps
module tb_fluid_dispense_ctrl;
    localparam int NF = 4;
    localparam int NU = 16;
`ifdef DISPENSE_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, restock_valid, abort, resp_valid, resp_ready;
    logic [3:0]  req_user, valve_open, low_stock;
    logic [2:0]  req_fluid, restock_fluid;
    logic [7:0]  req_vol, resp_visits, resp_disc;
    logic [15:0] restock_amt, resp_orig, resp_final, resp_remaining;
    logic [1:0]  resp_status;

    int vecs = 0;
    int errs = 0;
    int m_stock [NF];
    int m_visits [NU];
    int cap_final, cap_rem, cap_orig, cap_vis, cap_st;

    fluid_dispense_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_user(req_user), .req_fluid(req_fluid), .req_vol(req_vol),
        .restock_valid(restock_valid), .restock_fluid(restock_fluid), .restock_amt(restock_amt),
        .abort(abort), .valve_open(valve_open), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_visits(resp_visits), .resp_disc(resp_disc),
        .resp_orig(resp_orig), .resp_final(resp_final), .resp_remaining(resp_remaining),
        .low_stock(low_stock)
    );

    always #5 clk = ~clk;

    function automatic int price_of(input int f);
        case (f)
            0: return 10;
            1: return 30;
            2: return 50;
            default: return 80;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) m_stock[i] = 100;
        for (int i = 0; i < NU; i++) m_visits[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 0; resp_ready = 0; restock_valid = 0; abort = 0;
        req_user = 0; req_fluid = 0; req_vol = 0; restock_fluid = 0; restock_amt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One purchase; restock pulses on edge rs_edge, abort high in the cycle ending at edge ab_edge
    // (edge 1 is the accept edge).
    task automatic run_req(input int user, input int fluid, input int vol, input int rs_edge_i,
                           input int rs_fluid, input int rs_amt, input int ab_edge, input int hold);
        int e_st, e_vis, e_disc, e_orig, e_final, e_rem, e_lat, e_d, v, n, vcnt, vbad, rs_edge;
        bit ok, ab_eff;
        logic [3:0]  onehot, e_low;
        logic [65:0] snap;
        rs_edge = rs_edge_i;
        e_st = 0; e_vis = 0; e_disc = 0; e_orig = 0; e_final = 0; e_rem = -1; e_d = 0; e_lat = 2; ok = 0;
        if (fluid >= NF || vol == 0) begin
            e_st = 2; e_vis = m_visits[user];
        end else if (vol > m_stock[fluid]) begin
            e_st = 1; e_vis = m_visits[user]; e_rem = m_stock[fluid];
        end else ok = 1;
        ab_eff = ok && ABORT_EN && ab_edge >= 4 && ab_edge <= 3 + vol;
        if (ok) e_lat = ab_eff ? ab_edge : 3 + vol;
        if (rs_edge < 2 || rs_edge > e_lat) rs_edge = 0;
        if (ok) begin
            v = (m_visits[user] >= 255) ? 255 : m_visits[user] + 1;
            m_visits[user] = v; e_vis = v;
            e_disc = (v < 3) ? 0 : (v == 3) ? 10 : 20;
            e_d = ab_eff ? ab_edge - 4 : vol;
            e_orig = e_d * price_of(fluid);
            if (e_orig > 65535) e_orig = 65535;
            e_final = e_orig - (e_orig * e_disc) / 100;
            e_st = ab_eff ? 3 : 0;
            m_stock[fluid] -= e_d;
            e_rem = m_stock[fluid] + ((rs_edge != 0 && rs_fluid == fluid) ? rs_amt : 0);
        end
        if (rs_edge != 0 && rs_fluid < NF)
            m_stock[rs_fluid] = (m_stock[rs_fluid] + rs_amt > 65535) ? 65535 : m_stock[rs_fluid] + rs_amt;

        req_valid = 1; req_user = 4'(user); req_fluid = 3'(fluid); req_vol = 8'(vol);
        restock_fluid = 3'(rs_fluid); restock_amt = 16'(rs_amt);
        vecs++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL accept: req_ready=%b want 1", req_ready); end
        @(posedge clk); n = 1; #1;
        req_valid = 0; req_user = 4'($urandom); req_fluid = 3'($urandom); req_vol = 8'($urandom);
        onehot = (fluid < NF) ? 4'(1 << fluid) : 4'b0;
        vcnt = 0; vbad = 0;
        while (1) begin
            restock_valid = (n + 1 == rs_edge);
            abort = (n + 1 == ab_edge);
            #1;
            if (onehot != 0 && valve_open === onehot) vcnt++;
            else if (valve_open !== 4'b0) vbad++;
            @(posedge clk); n++; #1;
            restock_valid = 0; abort = 0;
            if (resp_valid === 1'b1 || n >= 400) break;
        end
        vecs++;
        if (resp_valid !== 1'b1 || n != e_lat) begin
            errs++; $display("FAIL latency: resp_valid=%b after %0d cycles, want 1 after %0d", resp_valid, n, e_lat);
        end
        vecs++;
        if (vcnt != e_d || vbad != 0) begin
            errs++; $display("FAIL valve: %0d open cycles (%0d stray), want %0d", vcnt, vbad, e_d);
        end
        vecs++;
        if (resp_status !== 2'(e_st)) begin errs++; $display("FAIL status: got %0d want %0d", resp_status, e_st); end
        vecs++;
        if (resp_visits !== 8'(e_vis)) begin errs++; $display("FAIL visits: got %0d want %0d", resp_visits, e_vis); end
        vecs++;
        if (resp_disc !== 8'(e_disc)) begin errs++; $display("FAIL disc: got %0d want %0d", resp_disc, e_disc); end
        vecs++;
        if (resp_orig !== 16'(e_orig)) begin errs++; $display("FAIL orig: got %0d want %0d", resp_orig, e_orig); end
        vecs++;
        if (resp_final !== 16'(e_final)) begin errs++; $display("FAIL final: got %0d want %0d", resp_final, e_final); end
        if (e_rem >= 0) begin
            vecs++;
            if (resp_remaining !== 16'(e_rem)) begin
                errs++; $display("FAIL remaining: got %0d want %0d", resp_remaining, e_rem);
            end
        end
        cap_final = resp_final; cap_rem = resp_remaining; cap_orig = resp_orig;
        cap_vis = resp_visits; cap_st = resp_status;
        snap = {resp_status, resp_visits, resp_disc, resp_orig, resp_final, resp_remaining};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            vecs++;
            if (resp_valid !== 1'b1 ||
                {resp_status, resp_visits, resp_disc, resp_orig, resp_final, resp_remaining} !== snap) begin
                errs++; $display("FAIL hold: resp_valid=%b fields %h want 1 and %h", resp_valid,
                    {resp_status, resp_visits, resp_disc, resp_orig, resp_final, resp_remaining}, snap);
            end
        end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        vecs++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errs++; $display("FAIL release: resp_valid=%b req_ready=%b want 0 1", resp_valid, req_ready);
        end
        for (int i = 0; i < NF; i++) e_low[i] = m_stock[i] < 10;
        vecs++;
        if (low_stock !== e_low) begin errs++; $display("FAIL low_stock: got %b want %b", low_stock, e_low); end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || valve_open !== 4'b0 || low_stock !== 4'b0 ||
            {resp_status, resp_visits, resp_disc, resp_orig, resp_final, resp_remaining} !== 66'b0) begin
            errs++; $display("FAIL reset_state: ready=%b valid=%b valve=%b low=%b want 1 0 0000 0000 and zero resp",
                req_ready, resp_valid, valve_open, low_stock);
        end
    endtask

    task automatic test_loyalty();
        int ef [4] = '{10, 20, 27, 32};
        int er [4] = '{99, 97, 94, 90};
        for (int i = 0; i < 4; i++) begin
            run_req(1, 0, i + 1, 0, 0, 0, 0, i);
            vecs++;
            if (cap_final != ef[i] || cap_rem != er[i]) begin
                errs++; $display("FAIL loyalty%0d: final=%0d rem=%0d want %0d %0d", i, cap_final, cap_rem, ef[i], er[i]);
            end
        end
    endtask

    task automatic test_stock();
        run_req(5, 2, 50, 0, 0, 0, 0, 0);
        run_req(5, 2, 50, 0, 0, 0, 0, 1);
        vecs++;
        if (low_stock[2] !== 1'b1) begin errs++; $display("FAIL low2: got %b want 1", low_stock[2]); end
        run_req(5, 2, 1, 0, 0, 0, 0, 0);
        run_req(6, 2, 1, 2, 2, 20, 0, 0);   // restock in LOOKUP cannot rescue
        run_req(7, 0, 3, 4, 2, 20, 0, 0);   // restock fluid 2 while fluid 0 pours
        run_req(7, 2, 5, 5, 2, 7, 0, 0);    // same-channel restock nets amt-1 that cycle
    endtask

    task automatic test_bad_req();
        run_req(2, 5, 3, 0, 0, 0, 0, 3);
        run_req(2, 1, 0, 0, 0, 0, 0, 3);
        run_req(2, 7, 0, 2, 1, 5, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            int f, vol;
            f   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
            vol = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 70) : $urandom_range(0, 12);
            run_req($urandom_range(0, NU - 1), f, vol,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(2, 3 + vol) : 0,
                    $urandom_range(0, 4), $urandom_range(1, 60),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3 + vol) : 0,
                    $urandom_range(0, 2));
        end
    endtask

    task automatic test_visit_sat();
        for (int k = 0; k < 256; k++) run_req(9, 0, 1, 3, 0, 1, 0, 0);
        vecs++;
        if (cap_vis != 255) begin errs++; $display("FAIL visit_sat: got %0d want 255", cap_vis); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_req(3, 1, 10, 0, 0, 0, 0, 0);
        req_valid = 1; req_user = 3; req_fluid = 1; req_vol = 6;
        @(posedge clk); #1 req_valid = 0;
        repeat (3) @(posedge clk);
        #3;
        vecs++;
        if (valve_open !== 4'b0010) begin errs++; $display("FAIL mid_valve: got %b want 0010", valve_open); end
        reset = 1;
        #1;
        vecs++;
        if (valve_open !== 4'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errs++; $display("FAIL async_reset: valve=%b ready=%b valid=%b want 0000 1 0", valve_open, req_ready, resp_valid);
        end
        @(negedge clk) reset = 0;
        model_reset();
        for (int f = 0; f < NF; f++) run_req(0, f, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_abort();
        do_reset();
        run_req(4, 1, 5, 0, 0, 0, 6, 1);
        if (ABORT_EN) begin
            vecs++;
            if (cap_st != 3 || cap_orig != 60 || cap_rem != 98) begin
                errs++; $display("FAIL abort: st=%0d orig=%0d rem=%0d want 3 60 98", cap_st, cap_orig, cap_rem);
            end
        end
        run_req(4, 1, 2, 0, 0, 0, 2, 0);    // abort outside DISPENSE has no effect
        run_req(4, 2, 4, 0, 0, 0, 4, 0);
    endtask

    initial begin
        test_reset();
        test_loyalty();
        test_stock();
        test_bad_req();
        test_back_to_back();
        test_visit_sat();
        test_reset_mid();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
